vedic_mac_accum: RTL and testbench
==================================

// Module: vedic_mac_accum
// PURPOSE
//  Downstream consumer of the 8x8 Vedic multiplier's 16-bit product.
//  Accumulates a programmed number of products (dot-product / MAC) into a wide unsigned
//  accumulator, with valid/ready handshakes on both sides.
//  Drains the result LSB-first, one byte per handshake, so it fits the 8-bit TinyTapeout pin budget.
// PARAMETERS
//  PROD_W  16  product width from the multiplier (unsigned)
//  ACC_W   24  accumulator width; must be a multiple of 8; NBYTES = ACC_W/8
//  LEN_W    8  term-count field width; len==0 means 2**LEN_W terms
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       begin a run; sampled only in IDLE
//  len        in   LEN_W   number of products to accumulate; sampled with start
//  in_valid   in   1       in_prod is valid
//  in_ready   out  1       block accepts in_prod this cycle
//  in_prod    in   PROD_W  product from multiplier
//  out_valid  out  1       out_byte is valid
//  out_ready  in   1       consumer takes out_byte this cycle
//  out_byte   out  8       result byte, LSB first
//  out_last   out  1       high with the final (MS) byte
//  busy       out  1       high in any state other than IDLE
//  ovf        out  1       sticky: accumulation saturated this run
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; acc, remaining count, byte index, ovf=0.
//    Outputs in_ready, out_valid, out_byte, out_last, busy all 0.
//  - FSM IDLE -> ACCUM -> DRAIN -> IDLE.
//  - IDLE: in_ready=0, out_valid=0.
//    On start: acc<=0, ovf<=0, remaining<=len (0 => 2**LEN_W), next state ACCUM.
//    in_valid in IDLE is ignored; acc is unchanged.
//  - ACCUM: in_ready=1.
//    On in_valid&in_ready: acc <= sat(acc + zero-extended in_prod), remaining-=1.
//    On the handshake with remaining==1, next state is DRAIN.
//    The sum is computed at ACC_W+1 bits. If the carry is set, acc<=all-ones and ovf<=1.
//    Once saturated, acc stays all-ones for the rest of the run.
//  - DRAIN: out_valid=1, out_byte=acc[8*idx +: 8], idx starts at 0; out_last = (idx==NBYTES-1).
//    On out_valid&out_ready: idx+=1. On the handshake with out_last, next state IDLE and idx<=0.
//  - out_byte and out_last are held stable while out_valid & !out_ready (no change under backpressure).
//  - start asserted outside IDLE is ignored; len is not re-sampled.
//  - Latency: first out_valid is 1 cycle after the last input handshake.
//    Full drain takes NBYTES handshakes; back-to-back runs are possible the cycle after the last byte.
//  - ovf stays valid through DRAIN and IDLE; it clears on the next start or on rst.
//  - Default widths cannot overflow: 256*255*255 = 0xFE0100 < 2**24. ovf only matters with smaller ACC_W.
// STRUCTURE
//  - Shared package vedic_pkg: FSM state encoding (IDLE/ACCUM/DRAIN) and the PROD_W default,
//    which is also used by the multiplier wrapper.
//  - One sub-module: vedic_byte_ser, an ACC_W-to-8 LSB-first serializer.
//    It owns idx, out_valid/out_ready, out_byte and out_last, and takes a load pulse from the FSM.
//  - Saturating adder and counters stay in this module.
// TESTING
//  1. len=3, products 0x0100, 0x0200, 0xFFFF -> bytes FF, 02, 01; out_last on 3rd byte; ovf=0.
//  2. len=0, 256 x 0xFE01 -> bytes 00, 01, FE; ovf=0; busy low the cycle after the last byte.
//  3. ACC_W=16, len=2, products 0xFFFF, 0x0002 -> acc saturates.
//     Bytes FF, FF; ovf=1 until the next start.
//  4. In DRAIN, hold out_ready=0 for 5 cycles -> out_valid=1 and out_byte=first byte stable all 5 cycles;
//     in_ready=0. Start pulse during DRAIN is ignored.
//  5. Reset mid-ACCUM after 2 of 3 terms -> all outputs 0 and IDLE immediately.
//     Then start len=1 with 0x0005 -> bytes 05, 00, 00.
//  6. in_valid=1 with 0x1234 while IDLE, then start len=1 with 0x0001 -> bytes 01, 00, 00
//     (the IDLE input is not accumulated).

Source files
------------

// File: rtl/vedic_pkg.sv
// vedic_pkg: definitions shared by the Vedic multiplier wrapper and the MAC
// accumulator that consumes its products.
//   PROD_W_DEF : width of the unsigned product leaving the 8x8 multiplier
//   state_t    : control states of the accumulator (IDLE -> ACCUM -> DRAIN)
package vedic_pkg;

  localparam int PROD_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/vedic_byte_ser.sv
// vedic_byte_ser: ACC_W-to-8 serializer, least significant byte first.
//   clk, rst   : clock and asynchronous active-high reset
//   load       : one-cycle pulse capturing data; out_valid rises the next cycle
//   data       : word to serialize
//   out_ready  : consumer accepts out_byte this cycle
//   out_valid  : out_byte is valid
//   out_byte   : current byte; held stable while out_valid & !out_ready
//   out_last   : high together with the most significant byte
//   done       : combinational pulse on the handshake of the last byte
module vedic_byte_ser #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ACC_W-1:0] data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             done
);

  localparam int NBYTES = ACC_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  // Bytes not yet presented, already shifted so the next one sits in [7:0].
  logic [ACC_W-1:0] hold;
  logic [IDX_W-1:0] idx;
  logic             fire;

  assign fire = out_valid & out_ready;
  assign done = fire & out_last;

  // Byte index, pending data and registered output byte/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= {ACC_W{1'b0}};
      idx       <= {IDX_W{1'b0}};
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_last  <= 1'b0;
    end else if (load) begin
      hold      <= data >> 8;
      idx       <= {IDX_W{1'b0}};
      out_valid <= 1'b1;
      out_byte  <= data[7:0];
      out_last  <= (LAST_IDX == {IDX_W{1'b0}});
    end else if (fire) begin
      if (out_last) begin
        hold      <= {ACC_W{1'b0}};
        idx       <= {IDX_W{1'b0}};
        out_valid <= 1'b0;
        out_byte  <= 8'h00;
        out_last  <= 1'b0;
      end else begin
        hold      <= hold >> 8;
        idx       <= idx + IDX_W'(1);
        out_valid <= 1'b1;
        out_byte  <= hold[7:0];
        out_last  <= ((idx + IDX_W'(1)) == LAST_IDX);
      end
    end else begin
      hold      <= hold;
      idx       <= idx;
      out_valid <= out_valid;
      out_byte  <= out_byte;
      out_last  <= out_last;
    end
  end

endmodule

// File: rtl/vedic_mac_accum.sv
// vedic_mac_accum: accumulates a programmed number of unsigned multiplier
// products into a saturating ACC_W-bit accumulator, then drains the result
// LSB-first one byte per handshake.
//   clk, rst          : clock and asynchronous active-high reset
//   start, len        : begin a run of len terms (len==0 means 2**LEN_W); IDLE only
//   in_valid/in_ready : product handshake, in_prod is the product
//   out_valid/out_ready, out_byte, out_last : byte drain handshake
//   busy              : not IDLE
//   ovf               : sticky saturation flag for the current/last run
module vedic_mac_accum
  import vedic_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              busy,
  output logic              ovf
);

  localparam int SUM_W = ACC_W + 1;

  state_t           state;
  state_t           next_state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sat;
  logic [SUM_W-1:0] sum;
  // One extra bit so that len==0 can hold the full 2**LEN_W term count.
  logic [LEN_W:0]   remaining;
  logic             in_fire;
  logic             last_term;
  logic             drain_done;

  assign in_fire   = in_valid & in_ready;
  assign last_term = in_fire & (remaining == {{LEN_W{1'b0}}, 1'b1});

  // Saturating add: the carry out of the ACC_W+1-bit sum forces all-ones.
  always_comb begin
    sum     = {1'b0, acc} + {{(SUM_W - PROD_W){1'b0}}, in_prod};
    acc_sat = sum[ACC_W-1:0];
    if (sum[ACC_W]) begin
      acc_sat = {ACC_W{1'b1}};
    end else begin
      acc_sat = sum[ACC_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_ACCUM;
        else       next_state = ST_IDLE;
      end
      ST_ACCUM: begin
        if (last_term) next_state = ST_DRAIN;
        else           next_state = ST_ACCUM;
      end
      ST_DRAIN: begin
        if (drain_done) next_state = ST_IDLE;
        else            next_state = ST_DRAIN;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      ST_DRAIN: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Accumulator, term counter and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= {ACC_W{1'b0}};
      remaining <= {(LEN_W + 1){1'b0}};
      ovf       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc       <= {ACC_W{1'b0}};
            ovf       <= 1'b0;
            remaining <= (len == {LEN_W{1'b0}}) ? {1'b1, {LEN_W{1'b0}}}
                                                : {1'b0, len};
          end else begin
            acc       <= acc;
            ovf       <= ovf;
            remaining <= remaining;
          end
        end
        ST_ACCUM: begin
          if (in_fire) begin
            acc       <= acc_sat;
            remaining <= remaining - {{LEN_W{1'b0}}, 1'b1};
            ovf       <= ovf | sum[ACC_W];
          end else begin
            acc       <= acc;
            remaining <= remaining;
            ovf       <= ovf;
          end
        end
        default: begin
          acc       <= acc;
          remaining <= remaining;
          ovf       <= ovf;
        end
      endcase
    end
  end

  // The final sum goes straight into the serializer, so the first byte is
  // valid one cycle after the last input handshake.
  vedic_byte_ser #(
    .ACC_W (ACC_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (last_term),
    .data      (acc_sat),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .done      (drain_done)
  );

endmodule

// File: tb/tb_vedic_mac_accum.sv
module tb_vedic_mac_accum;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        out_ready;

  // Outputs of the default (ACC_W=24) instance.
  logic       in_ready_a, out_valid_a, out_last_a, busy_a, ovf_a;
  logic [7:0] out_byte_a;
  // Outputs of the narrow (ACC_W=16) instance.
  logic       in_ready_b, out_valid_b, out_last_b, busy_b, ovf_b;
  logic [7:0] out_byte_b;

  // Which instance the tasks observe: 0 = ACC_W 24, 1 = ACC_W 16.
  logic       sel;
  logic       obs_in_ready, obs_out_valid, obs_out_last, obs_busy, obs_ovf;
  logic [7:0] obs_out_byte;

  int checks;
  int failures;

  vedic_mac_accum #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_byte(out_byte_a),
    .out_last(out_last_a), .busy(busy_a), .ovf(ovf_a)
  );

  vedic_mac_accum #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_byte(out_byte_b),
    .out_last(out_last_b), .busy(busy_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (sel) begin
      obs_in_ready  = in_ready_b;
      obs_out_valid = out_valid_b;
      obs_out_byte  = out_byte_b;
      obs_out_last  = out_last_b;
      obs_busy      = busy_b;
      obs_ovf       = ovf_b;
    end else begin
      obs_in_ready  = in_ready_a;
      obs_out_valid = out_valid_a;
      obs_out_byte  = out_byte_a;
      obs_out_last  = out_last_a;
      obs_busy      = busy_a;
      obs_ovf       = ovf_a;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] l);
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_prod(input logic [15:0] p);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = p;
    n = 0;
    while (!obs_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_wait", {31'd0, obs_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] eb, input logic el);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (!obs_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, {31'd0, obs_out_valid}, 32'd1);
    check_eq({tag, "_byte"}, {24'd0, obs_out_byte}, {24'd0, eb});
    check_eq({tag, "_last"}, {31'd0, obs_out_last}, {31'd0, el});
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Let whichever instance still has bytes pending finish its drain.
  task automatic flush();
    @(negedge clk);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; len = 8'd0;
    in_valid = 1'b0; in_prod = 16'h0000; out_ready = 1'b0; sel = 1'b0;
    checks = 0; failures = 0;

    // Reset state.
    #12;
    check_eq("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check_eq("rst_out_byte", {24'd0, out_byte_a}, 32'd0);
    check_eq("rst_out_last", {31'd0, out_last_a}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: three terms, 0x0100 + 0x0200 + 0xFFFF = 0x0102FF.
    do_start(8'd3);
    check_eq("t1_busy", {31'd0, obs_busy}, 32'd1);
    send_prod(16'h0100);
    send_prod(16'h0200);
    send_prod(16'hFFFF);
    @(negedge clk);
    check_eq("t1_latency_valid", {31'd0, obs_out_valid}, 32'd1);
    check_eq("t1_drain_in_ready", {31'd0, obs_in_ready}, 32'd0);
    recv_byte("t1_b0", 8'hFF, 1'b0);
    recv_byte("t1_b1", 8'h02, 1'b0);
    recv_byte("t1_b2", 8'h01, 1'b1);
    check_eq("t1_ovf", {31'd0, obs_ovf}, 32'd0);
    flush();

    // 2: len=0 means 256 terms; 256 * 0xFE01 = 0xFE0100.
    do_start(8'd0);
    for (int i = 0; i < 256; i++) send_prod(16'hFE01);
    recv_byte("t2_b0", 8'h00, 1'b0);
    recv_byte("t2_b1", 8'h01, 1'b0);
    recv_byte("t2_b2", 8'hFE, 1'b1);
    @(negedge clk);
    check_eq("t2_busy_after", {31'd0, obs_busy}, 32'd0);
    check_eq("t2_ovf", {31'd0, obs_ovf}, 32'd0);
    flush();

    // 3: ACC_W=16, 0xFFFF + 0x0002 saturates to 0xFFFF.
    sel = 1'b1;
    do_start(8'd2);
    send_prod(16'hFFFF);
    send_prod(16'h0002);
    recv_byte("t3_b0", 8'hFF, 1'b0);
    recv_byte("t3_b1", 8'hFF, 1'b1);
    flush();
    check_eq("t3_ovf_idle", {31'd0, obs_ovf}, 32'd1);
    check_eq("t3_busy_idle", {31'd0, obs_busy}, 32'd0);

    // 4: backpressure in DRAIN, start pulse ignored; 0x11 + 0x22 = 0x33.
    do_start(8'd2);
    check_eq("t4_ovf_cleared", {31'd0, ovf_b}, 32'd0);
    sel = 1'b0;
    send_prod(16'h0011);
    send_prod(16'h0022);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t4_hold_valid", {31'd0, obs_out_valid}, 32'd1);
      check_eq("t4_hold_byte", {24'd0, obs_out_byte}, 32'h33);
      check_eq("t4_hold_in_ready", {31'd0, obs_in_ready}, 32'd0);
      if (i == 1) begin
        start = 1'b1;
        len   = 8'd5;
      end else begin
        start = 1'b0;
      end
    end
    recv_byte("t4_b0", 8'h33, 1'b0);
    recv_byte("t4_b1", 8'h00, 1'b0);
    recv_byte("t4_b2", 8'h00, 1'b1);
    @(negedge clk);
    check_eq("t4_busy_after", {31'd0, obs_busy}, 32'd0);
    flush();

    // 5: reset mid-ACCUM, then a fresh single-term run.
    do_start(8'd3);
    send_prod(16'h0007);
    send_prod(16'h0009);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_rst_in_ready", {31'd0, obs_in_ready}, 32'd0);
    check_eq("t5_rst_busy", {31'd0, obs_busy}, 32'd0);
    check_eq("t5_rst_out_valid", {31'd0, obs_out_valid}, 32'd0);
    check_eq("t5_rst_out_byte", {24'd0, obs_out_byte}, 32'd0);
    check_eq("t5_rst_out_last", {31'd0, obs_out_last}, 32'd0);
    check_eq("t5_rst_ovf", {31'd0, obs_ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_start(8'd1);
    send_prod(16'h0005);
    recv_byte("t5_b0", 8'h05, 1'b0);
    recv_byte("t5_b1", 8'h00, 1'b0);
    recv_byte("t5_b2", 8'h00, 1'b1);
    flush();

    // 6: input offered while IDLE must not be accumulated.
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = 16'h1234;
    repeat (2) @(negedge clk);
    check_eq("t6_idle_in_ready", {31'd0, obs_in_ready}, 32'd0);
    in_valid = 1'b0;
    do_start(8'd1);
    send_prod(16'h0001);
    recv_byte("t6_b0", 8'h01, 1'b0);
    recv_byte("t6_b1", 8'h00, 1'b0);
    recv_byte("t6_b2", 8'h00, 1'b1);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
